// File: rtl/shift_key_conditioner.sv
// rtl/shift_key_conditioner.sv - button synchroniser, debouncer and step/auto-repeat pulse generator
//
// Optional feature macro: SHIFT_AUTOREPEAT_EN
//   defined   : IDLE -> DELAY -> REPEAT hold-to-repeat stepping
//   undefined : one step per press, then HOLD until release or conflict
//
// Ports:
//   clk_50m          in   system clock
//   rst              in   synchronous active-low reset
//   pause            in   high freezes stepping (debounce keeps running)
//   left_shift_raw   in   raw left button, asynchronous
//   right_shift_raw  in   raw right button, asynchronous
//   left_level       out  debounced left level
//   right_level      out  debounced right level
//   left_step        out  one-cycle left move pulse
//   right_step       out  one-cycle right move pulse
//   repeating        out  high while auto-repeating

module shift_key_conditioner #(
  parameter int unsigned DEBOUNCE_CYC  = 1000000,
  parameter int unsigned REPEAT_DELAY  = 15000000,
  parameter int unsigned REPEAT_PERIOD = 5000000,
  parameter int unsigned CNT_W         = 24
) (
  input  logic clk_50m,
  input  logic rst,
  input  logic pause,
  input  logic left_shift_raw,
  input  logic right_shift_raw,
  output logic left_level,
  output logic right_level,
  output logic left_step,
  output logic right_step,
  output logic repeating
);

  // Parameter sanity: every count must be non-zero and fit in CNT_W bits.
  if (CNT_W < 1 || DEBOUNCE_CYC < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1 ||
      (CNT_W < 32 && ((DEBOUNCE_CYC >> CNT_W) != 0 ||
                      (REPEAT_DELAY >> CNT_W) != 0 ||
                      (REPEAT_PERIOD >> CNT_W) != 0))) begin : g_cfg_err
    $error("shift_key_conditioner: bad counter configuration");
  end

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  // Channel index 0 = left, 1 = right.
  logic [1:0]       raw;
  logic [1:0]       sync1;
  logic [1:0]       sync2;
  logic [1:0]       level;
  logic [CNT_W-1:0] db_cnt [2];

  assign raw         = {right_shift_raw, left_shift_raw};
  assign left_level  = level[0];
  assign right_level = level[1];

  always_ff @(posedge clk_50m) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
      level <= '0;
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] >= DB_LAST) begin
          // Stable long enough: accept the new level.
          level[i]  <= ~level[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Exactly one key down; both down is a conflict and counts as not held.
  logic held;
  logic dir;      // 1 = right
  logic held_dir; // direction captured when the press was accepted

  assign held = level[0] ^ level[1];
  assign dir  = level[1];

`ifdef SHIFT_AUTOREPEAT_EN

  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_REPEAT} state_t;

  state_t           state;
  logic [CNT_W-1:0] timer;

  always_ff @(posedge clk_50m) begin
    if (!rst) begin
      state      <= S_IDLE;
      held_dir   <= 1'b0;
      timer      <= '0;
      left_step  <= 1'b0;
      right_step <= 1'b0;
      repeating  <= 1'b0;
    end else begin
      left_step  <= 1'b0;
      right_step <= 1'b0;
      // Pause freezes state and timer; the step outputs stay low.
      if (!pause) begin
        case (state)
          S_IDLE: begin
            if (held) begin
              held_dir   <= dir;
              left_step  <= ~dir;
              right_step <= dir;
              timer      <= '0;
              state      <= S_DELAY;
            end
          end
          S_DELAY: begin
            if (!held || dir != held_dir) begin
              state <= S_IDLE;
            end else if (timer >= RD_LAST) begin
              left_step  <= ~held_dir;
              right_step <= held_dir;
              timer      <= '0;
              state      <= S_REPEAT;
              repeating  <= 1'b1;
            end else begin
              timer <= timer + 1'b1;
            end
          end
          S_REPEAT: begin
            if (!held || dir != held_dir) begin
              state     <= S_IDLE;
              repeating <= 1'b0;
            end else if (timer >= RP_LAST) begin
              left_step  <= ~held_dir;
              right_step <= held_dir;
              timer      <= '0;
            end else begin
              timer <= timer + 1'b1;
            end
          end
          default: begin
            state     <= S_IDLE;
            repeating <= 1'b0;
          end
        endcase
      end
    end
  end

`else

  typedef enum logic [1:0] {S_IDLE, S_HOLD} state_t;

  state_t state;

  assign repeating = 1'b0;

  always_ff @(posedge clk_50m) begin
    if (!rst) begin
      state      <= S_IDLE;
      held_dir   <= 1'b0;
      left_step  <= 1'b0;
      right_step <= 1'b0;
    end else begin
      left_step  <= 1'b0;
      right_step <= 1'b0;
      if (!pause) begin
        case (state)
          S_IDLE: begin
            if (held) begin
              held_dir   <= dir;
              left_step  <= ~dir;
              right_step <= dir;
              state      <= S_HOLD;
            end
          end
          S_HOLD: begin
            if (!held || dir != held_dir) state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

`endif

endmodule

// File: doc/shift_key_conditioner.md
Name: shift_key_conditioner

Overview:
Input-conditioning stage directly upstream of the left/right shift counter. It synchronises and debounces the raw left/right push-buttons, resolves conflicts between them, and emits single-cycle step pulses with hold-to-repeat. Its outputs replace the raw `left_shift`/`right_shift` drive into the shift counter, so the player gets one move per press plus steady movement while a key is held.

Parameters:
- DEBOUNCE_CYC, 1000000, cycles a synchronised input must stay stable before the debounced level changes (20 ms at 50 MHz).
- REPEAT_DELAY, 15000000, cycles from the first step pulse to the first repeat pulse (300 ms).
- REPEAT_PERIOD, 5000000, cycles between successive repeat pulses (100 ms).
- CNT_W, 24, width of the debounce and repeat counters; must hold max(DEBOUNCE_CYC, REPEAT_DELAY, REPEAT_PERIOD).

Ports:
- clk_50m  in  1  system clock, 50 MHz; the only clock.
- rst  in  1  reset; synchronous, active-low.
- pause  in  1  high freezes stepping.
- left_shift_raw  in  1  raw left button, active-high, asynchronous.
- right_shift_raw  in  1  raw right button, active-high, asynchronous.
- left_level  out  1  debounced left level.
- right_level  out  1  debounced right level.
- left_step  out  1  one-cycle left move pulse.
- right_step  out  1  one-cycle right move pulse.
- repeating  out  1  high while in the REPEAT state.

Behaviour:
- Reset (rst low at a clk_50m edge):
  - All outputs are 0.
  - Synchronisers, counters and levels are cleared.
  - The FSM goes to IDLE.
  - Reset mid-hold discards all history, so a key still held after reset is seen as a fresh press once it is debounced.
- Synchronisation: each raw input passes through a 2-flop synchroniser.
- Debounce, per channel:
  - If the synchronised value equals the current level, the counter is cleared.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYC-1, the level toggles and the counter clears.
  - A bounce shorter than DEBOUNCE_CYC produces no level change.
  - Latency from a clean raw edge to a level change is DEBOUNCE_CYC+2 cycles.
- `held` is defined as exactly one debounced level high; `dir` records which one.
- FSM states: IDLE, DELAY, REPEAT.
  - IDLE -> DELAY when held. On the cycle after the level rise, the matching step pulses for one cycle and the timer clears.
  - DELAY: the timer counts to REPEAT_DELAY-1. Then the FSM emits a step, clears the timer and goes to REPEAT.
  - REPEAT: the timer counts to REPEAT_PERIOD-1. Then the FSM emits a step and clears the timer.
  - DELAY/REPEAT -> IDLE when the held key is released, or when both levels are high (conflict). No pulse is emitted on that cycle.
- Conflict:
  - While both levels are high, no pulses are emitted.
  - When one key is released, leaving exactly one held, IDLE treats the remaining key as a new press: a step is emitted on the next cycle.
  - A simultaneous rise of both levels gives no pulse.
- Pause:
  - While pause is high, the step outputs are forced to 0 and the FSM state and timer hold.
  - Debouncing continues.
  - On pause falling: if the state is not IDLE and the key is still held, timing resumes from the held count.
  - A press that first becomes held during pause produces its initial step on the first unpaused cycle.
- left_step and right_step are never high in the same cycle.
- Counters saturate; they never wrap.

Optional Feature:
- Macro: SHIFT_AUTOREPEAT_EN.
- Defined: behaviour as above.
- Undefined:
  - The DELAY and REPEAT states and the repeat timer are omitted.
  - Exactly one step is emitted per press, after which the FSM waits in a HOLD state until release or conflict, then returns to IDLE.
  - repeating is tied to 0.

Test Plan (bench parameters: DEBOUNCE_CYC=4, REPEAT_DELAY=10, REPEAT_PERIOD=3):
1. Reset behaviour: rst low for 3 cycles with left_shift_raw held high -> all outputs 0 during reset. After release, left_level rises 6 cycles later and left_step pulses one cycle after that.
2. Bounce rejection: left_shift_raw toggles with 2-cycle highs for 20 cycles -> left_level stays 0 and no steps occur.
3. Auto-repeat: right_shift_raw held for 40 cycles -> right_step at T0, T0+10, T0+13, T0+16 ... and repeating rises at T0+10. After release and debounce: state IDLE, no further pulses.
4. Conflict: left held in REPEAT, then right pressed -> once right_level rises, pulses stop and repeating=0. Release left -> right_step pulses one cycle after left_level falls.
5. Pause mid-DELAY: pause high for 20 cycles starting 5 cycles into DELAY -> no pulses during pause. The first repeat pulse arrives 5 cycles after pause falls.
6. With SHIFT_AUTOREPEAT_EN undefined: left held for 40 cycles -> exactly one left_step and repeating stays 0.
